// File: rtl/wport_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Holds queue/starvation defaults, the write request struct and the grant encoding.
package wport_arbiter_pkg;

    localparam int WPORT_STARVE_MAX = 4;
    localparam int WPORT_DEPTH      = 2;

    // Field "rd" is the destination register ("reg" is a reserved word).
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wport_req_t;

    localparam int WPORT_REQ_W = $bits(wport_req_t);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LQ   = 2'd2
    } wport_grant_t;

endpackage

// File: rtl/wport_fifo.sv
// DEPTH-entry synchronous FIFO holding long-latency results awaiting the write port.
// Registered occupancy is exported so the arbiter can derive ready/grant from it.
module wport_fifo
    import wport_arbiter_pkg::*;
#(
    parameter int DEPTH = WPORT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [WPORT_REQ_W-1:0]        push_data,
    input  logic                          pop,
    output logic [WPORT_REQ_W-1:0]        head,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WPORT_REQ_W-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic                   wr_en;
    logic                   rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = push && (count != CW'(DEPTH));
    assign rd_en = pop && (count != '0);
    assign head  = mem[rd_ptr];

    // Storage carries no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wport_arbiter.sv
// Owns the single register-file write port, sharing it between the writeback stage
// and a small queue of long-latency results with a starvation guard on the queue.
module wport_arbiter
    import wport_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = WPORT_STARVE_MAX,
    parameter int DEPTH      = WPORT_DEPTH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_reg,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic [4:0]  wreg,
    output logic [31:0] wdata,
    output logic        wen
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CW-1:0]          count;
    logic [SW-1:0]          starve;
    logic [WPORT_REQ_W-1:0] head_bits;
    wport_req_t             head;
    wport_req_t             lu_req;
    wport_grant_t           grant;
    logic                   q_nonempty;
    logic                   starved;
    logic                   push;

    assign q_nonempty = (count != '0);
    assign starved    = (starve == SW'(STARVE_MAX));
    assign lu_ready   = (count != CW'(DEPTH));
    // Writes to r0 are dropped here so they never cost a port slot.
    assign push       = lu_valid && lu_ready && (lu_reg != 5'd0);
    assign lu_req     = '{rd: lu_reg, data: lu_data};
    assign head       = wport_req_t'(head_bits);

    wport_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (lu_req),
        .pop       (grant == GNT_LQ),
        .head      (head_bits),
        .count     (count)
    );

    always_comb begin
        grant = GNT_NONE;
        if (q_nonempty && starved)
            grant = GNT_LQ;
        else if (wb_valid)
            grant = GNT_WB;
        else if (q_nonempty)
            grant = GNT_LQ;
    end

    always_comb begin
        wen      = 1'b0;
        wb_stall = 1'b0;
        wreg     = wb_reg;
        wdata    = wb_data;
        case (grant)
            GNT_WB: wen = 1'b1;
            GNT_LQ: begin
                wen      = 1'b1;
                wb_stall = wb_valid;
                wreg     = head.rd;
                wdata    = head.data;
            end
            default: ;
        endcase
    end

    // Counts consecutive cycles a queued result lost the port to writeback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve <= '0;
        else if (!q_nonempty || grant == GNT_LQ)
            starve <= '0;
        else if (grant == GNT_WB && !starved)
            starve <= starve + 1'b1;
    end

    a_stall_needs_valid: assert property (@(posedge clk) disable iff (!reset_n)
        wb_stall |-> wb_valid);
    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CW'(DEPTH));

endmodule

// File: tb/tb_wport_arbiter.sv
// Bench for wport_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wport_arbiter;
    import wport_arbiter_pkg::*;

    localparam int SMAX = 4;
    localparam int DEP  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid, lu_valid;
    logic [4:0]  wb_reg, lu_reg;
    logic [31:0] wb_data, lu_data;
    logic        wb_stall, lu_ready, wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;

    int vectors     = 0;
    int miscompares = 0;

    wport_arbiter #(.STARVE_MAX(SMAX), .DEPTH(DEP)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wb_valid (wb_valid),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .wb_stall (wb_stall),
        .lu_valid (lu_valid),
        .lu_reg   (lu_reg),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .wreg     (wreg),
        .wdata    (wdata),
        .wen      (wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending results and a denial count.
    wport_req_t mq[$];
    int         m_starve;

    function automatic bit m_lq_wins();
        return (mq.size() != 0) && (m_starve >= SMAX || !wb_valid);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_starve = 0;
        end else begin
            bit lq, had;
            lq  = m_lq_wins();
            had = mq.size() != 0;
            if (lq) void'(mq.pop_front());
            if (!had || lq) m_starve = 0;
            else if (wb_valid && m_starve < SMAX) m_starve++;
            if (lu_valid && had + (lq ? -1 : 0) >= 0 && (mq.size() + (lq ? 1 : 0)) != DEP
                && lu_reg != 5'd0)
                mq.push_back('{rd: lu_reg, data: lu_data});
        end
    end

    always @(negedge clk) begin
        bit lq;
        lq = m_lq_wins();
        chk("m_lu_ready", lu_ready, (mq.size() != DEP));
        chk("m_wb_stall", wb_stall, wb_valid && lq);
        chk("m_wen", wen, lq || wb_valid);
        if (lq) begin
            chk("m_wreg_lq", wreg, mq[0].rd);
            chk("m_wdata_lq", wdata, mq[0].data);
        end else if (wb_valid) begin
            chk("m_wreg_wb", wreg, wb_reg);
            chk("m_wdata_wb", wdata, wb_data);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        lu_valid = 0; lu_reg = 0; lu_data = 0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1; wb_reg = r; wb_data = d;
    endtask

    task automatic lu(input logic [4:0] r, input logic [31:0] d);
        lu_valid = 1; lu_reg = r; lu_data = d;
    endtask

    initial begin
        reset_n = 0;
        idle();
        #3;
        chk("rst_lu_ready", lu_ready, 1);
        chk("rst_wb_stall", wb_stall, 0);
        chk("rst_wen0", wen, 0);
        wb(5'd6, 32'h66);
        #1;
        chk("rst_wen1", wen, 1);
        chk("rst_wreg", wreg, 6);
        #10;
        idle();
        reset_n = 1;

        // single lu transfer, written one cycle later
        nxt(); lu(5'd5, 32'h12345678);
        neg(); chk("t34_ready", lu_ready, 1); chk("t34_wen0", wen, 0);
        nxt(); idle();
        neg(); chk("t34_wen", wen, 1); chk("t34_wreg", wreg, 5); chk("t34_wdata", wdata, 32'h12345678);
        nxt();

        // simultaneous WB and lu
        wb(5'd3, 32'hA); lu(5'd4, 32'hB);
        neg(); chk("t35_wreg0", wreg, 3); chk("t35_wdata0", wdata, 32'hA); chk("t35_stall0", wb_stall, 0);
        nxt(); idle();
        neg(); chk("t35_wen1", wen, 1); chk("t35_wreg1", wreg, 4); chk("t35_wdata1", wdata, 32'hB);
        nxt();

        // starvation: WB wins 4 cycles, then the queued entry is forced through
        wb(5'd1, 32'h100); lu(5'd9, 32'h99);
        neg(); chk("t36_wreg_enq", wreg, 1);
        nxt(); lu_valid = 0;
        for (int i = 0; i < 6; i++) begin
            wb_data = 32'h200 + i;
            neg();
            chk($sformatf("t36_stall%0d", i), wb_stall, (i == 4));
            chk($sformatf("t36_wreg%0d", i), wreg, (i == 4) ? 9 : 1);
            nxt();
        end
        idle();

        // full queue holds lu_ready low until the cycle after a pop
        wb(5'd2, 32'h20); lu(5'd7, 32'h77);
        neg(); chk("t37_ready0", lu_ready, 1);
        nxt(); lu(5'd8, 32'h88);
        neg(); chk("t37_ready1", lu_ready, 1);
        nxt(); lu(5'd10, 32'hAA);
        for (int c = 2; c <= 5; c++) begin
            neg();
            chk($sformatf("t37_ready_c%0d", c), lu_ready, 0);
            chk($sformatf("t37_stall_c%0d", c), wb_stall, (c == 5));
            nxt();
        end
        neg(); chk("t37_ready_c6", lu_ready, 1);
        nxt(); idle();
        neg(); chk("t37_drain_b", wreg, 8); chk("t37_drain_bd", wdata, 32'h88);
        nxt();
        neg(); chk("t37_drain_c", wreg, 10); chk("t37_drain_cd", wdata, 32'hAA);
        nxt();
        neg(); chk("t37_empty", wen, 0);
        nxt();

        // r0 destination: handshake only
        lu(5'd0, 32'hDEAD);
        neg(); chk("t38_ready", lu_ready, 1);
        nxt(); idle();
        for (int i = 0; i < 2; i++) begin
            neg(); chk($sformatf("t38_nowen%0d", i), wen, 0); chk("t38_ready_after", lu_ready, 1);
            nxt();
        end

        // mid-cycle reset discards a full queue
        wb(5'd13, 32'hD0); lu(5'd11, 32'hB1);
        nxt(); lu(5'd12, 32'hC2);
        nxt(); lu_valid = 0;
        neg(); chk("t39_full", lu_ready, 0);
        nxt();
        #2 reset_n = 0;
        #1;
        chk("t39_ready", lu_ready, 1); chk("t39_stall", wb_stall, 0);
        chk("t39_wen", wen, 1); chk("t39_wreg", wreg, 13);
        #1 reset_n = 1;
        idle();
        for (int i = 0; i < 4; i++) begin
            neg(); chk($sformatf("t39_nowen%0d", i), wen, 0);
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
